// File: rtl/num_parse_pkg.sv
// num_parse_pkg: shared encodings for the ASCII number parser.
// States, format codes, error codes and format-code helpers.
package num_parse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_e;

  localparam logic [7:0] FC_BIN = 8'h42;
  localparam logic [7:0] FC_DEC = 8'h44;
  localparam logic [7:0] FC_HEX = 8'h48;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DIGIT = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_LEN   = 2'd3;

  function automatic logic fc_supported(
    input logic [7:0] f
  );
    return (f == FC_BIN) || (f == FC_DEC) ||
           (f == FC_HEX) || (f == 8'h00) ||
           ((f >= 8'h30) && (f <= 8'h39));
  endfunction

  function automatic logic [4:0] fc_base(
    input logic [7:0] f
  );
    logic [4:0] b;
    b = 5'd10;
    if (f == FC_BIN) b = 5'd2;
    if (f == FC_HEX) b = 5'd16;
    return b;
  endfunction

endpackage

// File: rtl/num_parse_ctrl_char2num.sv
// char2num: ASCII digit to 4-bit value.
// Letters A-F map only under the hex format code.
module char2num
  import num_parse_pkg::*;
(
  input  logic [7:0] char_in,
  input  logic [7:0] fc,
  output logic [3:0] num
);

  always_comb begin
    num = 4'd0;
    if ((char_in >= 8'h30) && (char_in <= 8'h39))
      num = char_in[3:0];
    else if ((fc == FC_HEX) &&
             (char_in >= 8'h41) && (char_in <= 8'h46))
      num = char_in[3:0] + 4'd9;
  end

endmodule

// File: rtl/num_parse_ctrl.sv
// num_parse_ctrl: sequences char2num over a serial digit stream
// and accumulates acc = acc*base + digit into one binary result.
module num_parse_ctrl
  import num_parse_pkg::*;
#(
  parameter int         W          = 32,
  parameter logic [7:0] TERM_CHAR  = 8'h0D,
  parameter logic [7:0] ALT_TERM   = 8'h20,
  parameter int         MAX_DIGITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   fc,
  input  logic         char_valid,
  input  logic [7:0]   char_in,
  output logic         char_ready,
  output logic         busy,
  output logic [W-1:0] num_out,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int XW = W + 5;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   num_q, num_d;
  logic [1:0]     ec_q, ec_d;
  logic [7:0]     fc_q, fc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [3:0]     dval;
  logic [4:0]     base;
  logic [XW-1:0]  prod;
  logic           xfer, is_term, is_dec, is_uhex, legal, ovf;

  char2num u_c2n (
    .char_in (char_in),
    .fc      (fc_q),
    .num     (dval)
  );

  assign char_ready = (state_q == ACCUM);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign num_out    = num_q;
  assign err_code   = ec_q;

  assign xfer    = char_valid & char_ready;
  assign is_term = (char_in == TERM_CHAR) ||
                   (char_in == ALT_TERM);
  assign is_dec  = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_uhex = (char_in >= 8'h41) && (char_in <= 8'h46);
  assign base    = fc_base(fc_q);
  assign prod    = XW'(acc_q) * XW'(base) + XW'(dval);
  assign ovf     = |prod[XW-1:W];

  always_comb begin
    legal = is_dec;
    if (base == 5'd2)
      legal = (char_in == 8'h30) || (char_in == 8'h31);
    else if (base == 5'd16)
      legal = is_dec | is_uhex;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    num_d   = num_q;
    ec_d    = ec_q;
    fc_d    = fc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          fc_d  = fc;
          acc_d = '0;
          cnt_d = '0;
          num_d = '0;
          ec_d  = ERR_NONE;
          if (fc_supported(fc)) begin
            state_d = ACCUM;
          end else begin
            ec_d    = ERR_DIGIT;
            state_d = ERR;
          end
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (is_term) begin
            if (cnt_q == '0) begin
              ec_d    = ERR_LEN;
              state_d = ERR;
            end else begin
              num_d   = acc_q;
              state_d = DONE;
            end
          end else if (legal) begin
            // Overflow wins over length when both apply.
            if (ovf) begin
              ec_d    = ERR_OVF;
              state_d = ERR;
            end else if (cnt_q == CW'(MAX_DIGITS)) begin
              ec_d    = ERR_LEN;
              state_d = ERR;
            end else begin
              acc_d = prod[W-1:0];
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            ec_d    = ERR_DIGIT;
            state_d = ERR;
          end
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        num_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      num_q   <= '0;
      ec_q    <= ERR_NONE;
      fc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      ec_q    <= ec_d;
      fc_q    <= fc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_num_parse_ctrl.sv
// tb_num_parse_ctrl: scoreboard bench for num_parse_ctrl.
// Expected results are queued at stimulus time, popped on done/err.
module tb_num_parse_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  fc;
  logic        char_valid;
  logic [7:0]  char_in;
  logic        char_ready;
  logic        busy;
  logic [31:0] num_out;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  typedef struct {
    bit          e;
    logic [1:0]  code;
    logic [31:0] num;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   prev_pulse = 1'b0;

  num_parse_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fc         (fc),
    .char_valid (char_valid),
    .char_in    (char_in),
    .char_ready (char_ready),
    .busy       (busy),
    .num_out    (num_out),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done || err) begin
        exp_t x;
        chk("both", {62'd0, done, err} == 64'd3, 0);
        chk("width", prev_pulse, 0);
        if (sb.size() == 0) begin
          chk("unexpected", {done, err}, 0);
        end else begin
          x = sb.pop_front();
          chk("kind", err, x.e);
          chk("num", num_out, x.num);
          chk("code", err_code, x.code);
        end
      end
      prev_pulse = done | err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic push(input bit e, input logic [1:0] c,
                      input logic [31:0] n);
    exp_t x;
    x.e = e; x.code = c; x.num = n;
    sb.push_back(x);
  endtask

  task automatic do_start(input logic [7:0] f);
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    fc = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    bit ok = 1'b0;
    int n = 0;
    char_valid = 1'b1; char_in = c;
    do begin
      @(negedge clk); ok = char_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 20);
    char_valid = 1'b0;
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic finish_chk(input bit e);
    @(negedge clk);
    chk("latency", {done, err}, e ? 2'b01 : 2'b10);
    @(negedge clk);
    chk("fall", {busy, done, err}, 0);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [7:0] f, input string s,
                     input logic [7:0] term, input bit e,
                     input logic [1:0] c, input logic [31:0] n);
    push(e, c, n);
    do_start(f);
    for (int i = 0; i < s.len(); i++) send(s[i]);
    if (term != 8'h00) send(term);
    finish_chk(e);
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    string s;
    rst = 1'b1; start = 1'b0; fc = 8'h00;
    char_valid = 1'b0; char_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {busy, char_ready, done, err, err_code}, 0);
    chk("rst_num", num_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(8'h44, "123", 8'h0D, 0, 2'd0, 32'd123);
    run(8'h48, "1FF", 8'h20, 0, 2'd0, 32'h1FF);
    chk("hold", num_out, 32'h1FF);
    run(8'h42, "101", 8'h0D, 0, 2'd0, 32'd5);
    run(8'h48, "1G", 8'h00, 1, 2'd1, 32'd0);
    run(8'h48, "1f", 8'h00, 1, 2'd1, 32'd0);
    run(8'h42, "2", 8'h00, 1, 2'd1, 32'd0);
    run(8'h44, "4294967296", 8'h00, 1, 2'd2, 32'd0);
    run(8'h44, "4294967295", 8'h0D, 0, 2'd0, 32'hFFFFFFFF);
    run(8'h44, "", 8'h0D, 1, 2'd3, 32'd0);
    run(8'h00, "0042", 8'h20, 0, 2'd0, 32'd42);
    run(8'h37, "9", 8'h0D, 0, 2'd0, 32'd9);

    // unsupported format: error without consuming the waiting char
    push(1, 2'd1, 32'd0);
    char_valid = 1'b1; char_in = 8'h31;
    do_start(8'h5A);
    chk("nf_ready", char_ready, 0);
    finish_chk(1);
    chk("nf_ready2", char_ready, 0);
    char_valid = 1'b0;

    s = "";
    for (int i = 0; i < 32; i++) s = {s, "1"};
    run(8'h42, s, 8'h0D, 0, 2'd0, 32'hFFFFFFFF);
    s = "";
    for (int i = 0; i < 32; i++) s = {s, "0"};
    run(8'h44, s, 8'h0D, 0, 2'd0, 32'd0);
    s = {s, "0"};
    run(8'h42, s, 8'h00, 1, 2'd3, 32'd0);

    // reset mid-parse discards everything
    run(8'h44, "55", 8'h0D, 0, 2'd0, 32'd55);
    do_start(8'h44);
    send("1"); send("2");
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", {busy, char_ready, done, err, err_code}, 0);
    chk("mid_rst_num", num_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(8'h44, "7", 8'h0D, 0, 2'd0, 32'd7);

    // start while busy must not relatch the format
    push(0, 2'd0, 32'd10);
    do_start(8'h44);
    send("1");
    fc = 8'h48; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send("0");
    send(8'h0D);
    finish_chk(0);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
